// File: rtl/invaders_pkg.sv
// Shared playfield geometry, FSM state type and helpers for the invader formation.
package invaders_pkg;

  localparam int SCREEN_W     = 640;
  localparam int INVADER_W    = 32;
  localparam int INVADER_H    = 16;
  localparam int SPACING      = 48;
  localparam int PLAYER_Y     = 440;
  localparam int NUM_INVADERS = 6;

  typedef enum logic [1:0] {
    ST_MOVE,
    ST_DROP,
    ST_BREACH,
    ST_WAVE_CLEAR
  } state_t;

  // Keeps only the least significant set bit (lowest invader index wins).
  function automatic logic [NUM_INVADERS-1:0] lowest_set(input logic [NUM_INVADERS-1:0] v);
    return v & ((~v) + NUM_INVADERS'(1));
  endfunction

endpackage

// File: rtl/invaders_hit_detect.sv
// Point-in-box test of the laser tip against one invader's half-open bounding box.
module invader_hit_detect
  import invaders_pkg::*;
(
  input  logic [10:0] box_x,
  input  logic [9:0]  box_y,
  input  logic [9:0]  laser_x,
  input  logic [9:0]  laser_y,
  output logic        hit
);

  logic [10:0] lx, ly, by;
  logic        in_x, in_y;

  assign lx   = {1'b0, laser_x};
  assign ly   = {1'b0, laser_y};
  assign by   = {1'b0, box_y};
  assign in_x = (lx >= box_x) && (lx < box_x + 11'(INVADER_W));
  assign in_y = (ly >= by) && (ly < by + 11'(INVADER_H));
  assign hit  = in_x && in_y;

endmodule

// File: rtl/invaders.sv
// Invader formation controller: movement FSM, alive mask and laser hit detection.
// Optional wave speed-up is enabled by defining INVADERS_SPEEDUP_EN.
module invaders
  import invaders_pkg::*;
#(
  parameter int START_X          = 64,
  parameter int START_Y          = 32,
  parameter int STEP_X           = 8,
  parameter int STEP_Y           = 16,
  parameter int STEP_FRAMES_INIT = 30,
  parameter int STEP_FRAMES_MIN  = 6,
  parameter int STEP_FRAMES_DEC  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arst,
  input  logic                    frame,
  input  logic                    laser_active,
  input  logic [9:0]              laser_x,
  input  logic [9:0]              laser_y,
  output logic [9:0]              invaders_x,
  output logic [9:0]              invaders_y,
  output logic [NUM_INVADERS-1:0] invader_alive,
  output logic [NUM_INVADERS-1:0] invader_collision,
  output logic                    player_collision
);

  state_t                  state, state_next;
  logic [9:0]              x_next, y_next;
  logic [NUM_INVADERS-1:0] alive_next, in_box, hits, survivors;
  logic                    dir_right, dir_next;
  logic [5:0]              cnt, cnt_next, period;
  logic                    any_reset, respawn;
  logic [10:0]             right_reach, y_drop;
  logic                    edge_right, edge_left, breach;

  for (genvar i = 0; i < NUM_INVADERS; i++) begin : g_hit
    invader_hit_detect u_hit (
      .box_x  ({1'b0, invaders_x} + 11'(i * SPACING)),
      .box_y  (invaders_y),
      .laser_x(laser_x),
      .laser_y(laser_y),
      .hit    (in_box[i])
    );
  end

  assign any_reset         = rst | arst;
  assign hits              = in_box & invader_alive & {NUM_INVADERS{laser_active}};
  assign invader_collision = (frame && !any_reset) ? lowest_set(hits) : '0;
  assign survivors         = invader_alive & ~invader_collision;

  // Edge and breach tests are widened to 11 bits so they can never wrap.
  assign right_reach = {1'b0, invaders_x} + 11'((NUM_INVADERS - 1) * SPACING + INVADER_W + STEP_X);
  assign edge_right  = right_reach > 11'(SCREEN_W);
  assign edge_left   = invaders_x < 10'(STEP_X);
  assign y_drop      = {1'b0, invaders_y} + 11'(STEP_Y);
  assign breach      = (y_drop + 11'(INVADER_H)) >= 11'(PLAYER_Y);

  always_ff @(posedge clk) begin
    if (any_reset) begin
      state         <= ST_MOVE;
      invaders_x    <= 10'(START_X);
      invaders_y    <= 10'(START_Y);
      invader_alive <= '1;
      dir_right     <= 1'b1;
      cnt           <= '0;
    end else begin
      state         <= state_next;
      invaders_x    <= x_next;
      invaders_y    <= y_next;
      invader_alive <= alive_next;
      dir_right     <= dir_next;
      cnt           <= cnt_next;
    end
  end

  always_comb begin
    state_next       = state;
    x_next           = invaders_x;
    y_next           = invaders_y;
    alive_next       = invader_alive;
    dir_next         = dir_right;
    cnt_next         = cnt;
    respawn          = 1'b0;
    player_collision = 1'b0;
    if (frame) begin
      alive_next = survivors;
      // Clearing the last invader pre-empts any drop or breach still pending.
      if (state == ST_WAVE_CLEAR) begin
        respawn = 1'b1;
      end else if (survivors == '0) begin
        state_next = ST_WAVE_CLEAR;
      end else begin
        case (state)
          ST_MOVE: begin
            if (cnt == period - 6'd1) begin
              cnt_next = '0;
              if (dir_right ? edge_right : edge_left) begin
                state_next = ST_DROP;
              end else begin
                x_next = dir_right ? invaders_x + 10'(STEP_X) : invaders_x - 10'(STEP_X);
              end
            end else begin
              cnt_next = cnt + 6'd1;
            end
          end
          ST_DROP: begin
            y_next     = y_drop[9:0];
            dir_next   = !dir_right;
            state_next = breach ? ST_BREACH : ST_MOVE;
          end
          ST_BREACH: begin
            player_collision = !any_reset;
            respawn          = 1'b1;
          end
          default: ;
        endcase
      end
      if (respawn) begin
        state_next = ST_MOVE;
        x_next     = 10'(START_X);
        y_next     = 10'(START_Y);
        alive_next = '1;
        dir_next   = 1'b1;
        cnt_next   = '0;
      end
    end
  end

`ifdef INVADERS_SPEEDUP_EN
  logic wave_respawn;

  assign wave_respawn = frame && (state == ST_WAVE_CLEAR);

  // Each cleared wave shortens the step period down to a floor.
  always_ff @(posedge clk) begin
    if (any_reset) begin
      period <= 6'(STEP_FRAMES_INIT);
    end else if (wave_respawn) begin
      period <= (period >= 6'(STEP_FRAMES_MIN + STEP_FRAMES_DEC))
                ? period - 6'(STEP_FRAMES_DEC) : 6'(STEP_FRAMES_MIN);
    end
  end
`else
  assign period = 6'(STEP_FRAMES_INIT);
`endif

endmodule

// File: tb/tb_invaders.sv
// Randomized scoreboard bench for invaders against a behavioural formation model.
module tb_invaders;

  localparam int SX = 64, SY = 32, DX = 8, DY = 16, PER0 = 30, PMIN = 6, PDEC = 4;
  localparam int SCR_W = 640, IW = 32, IH = 16, GAP = 48, PY = 440;

  logic       clk = 1'b0;
  logic       rst, arst, frame, laser_active;
  logic [9:0] laser_x, laser_y;
  logic [9:0] invaders_x, invaders_y;
  logic [5:0] invader_alive, invader_collision;
  logic       player_collision;

  invaders dut (
    .clk              (clk),
    .rst              (rst),
    .arst             (arst),
    .frame            (frame),
    .laser_active     (laser_active),
    .laser_x          (laser_x),
    .laser_y          (laser_y),
    .invaders_x       (invaders_x),
    .invaders_y       (invaders_y),
    .invader_alive    (invader_alive),
    .invader_collision(invader_collision),
    .player_collision (player_collision)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] col;
    logic       pc;
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] alive;
    bit         known;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model of the formation.
  int       mx, my, mdir, mper, mcnt, breaches;
  bit [5:0] malive;
  bit       pend_drop, pend_breach, pend_clear, known;

  task automatic respawnModel();
    mx = SX; my = SY; mdir = 1; mcnt = 0; malive = 6'h3F;
    pend_drop = 0; pend_breach = 0; pend_clear = 0;
  endtask

  task automatic applyStimulus(input bit r, input bit a, input bit f, input bit la,
                               input logic [9:0] lx, input logic [9:0] ly);
    exp_t     e;
    int       hit;
    bit [5:0] nalive;
    @(posedge clk);
    #1;
    rst = r; arst = a; frame = f; laser_active = la; laser_x = lx; laser_y = ly;
    e.col = '0; e.pc = 1'b0; e.x = 10'(mx); e.y = 10'(my); e.alive = malive; e.known = known;
    if (r || a) begin
      respawnModel();
      mper  = PER0;
      known = 1;
    end else if (f) begin
      hit = -1;
      if (la)
        for (int i = 0; i < 6; i++)
          if (hit < 0 && malive[i] && int'(lx) >= mx + GAP * i && int'(lx) < mx + GAP * i + IW
              && int'(ly) >= my && int'(ly) < my + IH)
            hit = i;
      if (hit >= 0) e.col[hit] = 1'b1;
      nalive = malive & ~e.col;
      if (pend_clear) begin
        respawnModel();
`ifdef INVADERS_SPEEDUP_EN
        mper = (mper - PDEC < PMIN) ? PMIN : mper - PDEC;
`endif
      end else if (nalive == 0) begin
        malive = 0; pend_clear = 1; pend_drop = 0; pend_breach = 0;
      end else begin
        malive = nalive;
        if (pend_breach) begin
          e.pc = 1'b1;
          breaches++;
          respawnModel();
        end else if (pend_drop) begin
          my = my + DY; mdir = -mdir; pend_drop = 0;
          if (my + IH >= PY) pend_breach = 1;
        end else if (mcnt == mper - 1) begin
          mcnt = 0;
          if ((mdir > 0 && mx + 5 * GAP + IW + DX > SCR_W) || (mdir < 0 && mx < DX)) pend_drop = 1;
          else mx = mx + DX * mdir;
        end else begin
          mcnt++;
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    n_checks++;
    if (invader_collision !== e.col) begin
      n_fail++;
      $display("[TB] FAIL invader_collision at %0t: got %b expected %b", $time, invader_collision, e.col);
    end
    n_checks++;
    if (player_collision !== e.pc) begin
      n_fail++;
      $display("[TB] FAIL player_collision at %0t: got %b expected %b", $time, player_collision, e.pc);
    end
    if (e.known) begin
      n_checks++;
      if (invaders_x !== e.x) begin
        n_fail++;
        $display("[TB] FAIL invaders_x at %0t: got %0d expected %0d", $time, invaders_x, e.x);
      end
      n_checks++;
      if (invaders_y !== e.y) begin
        n_fail++;
        $display("[TB] FAIL invaders_y at %0t: got %0d expected %0d", $time, invaders_y, e.y);
      end
      n_checks++;
      if (invader_alive !== e.alive) begin
        n_fail++;
        $display("[TB] FAIL invader_alive at %0t: got %h expected %h", $time, invader_alive, e.alive);
      end
    end
  endtask

  // Monitor: pops one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e);
    end
  end

  task automatic aimLaser(output logic [9:0] lx, output logic [9:0] ly);
    int i, ox, oy;
    i  = $urandom_range(0, 5);
    ox = $urandom_range(0, 33) - 1;
    oy = $urandom_range(0, 17) - 1;
    lx = 10'(mx + GAP * i + ox);
    ly = 10'(my + oy);
  endtask

  task automatic reportTimeout(input string what, input int budget);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got no event expected one within %0d cycles", what, budget);
  endtask

  initial begin
    logic [9:0] lx, ly;
    bit         r, a, f, la;
    int         b0, n;
    known = 0; breaches = 0; mx = 0; my = 0; mdir = 1; mper = PER0; mcnt = 0; malive = 0;
    pend_drop = 0; pend_breach = 0; pend_clear = 0;
    rst = 1; arst = 0; frame = 0; laser_active = 0; laser_x = 0; laser_y = 0;

    repeat (3) applyStimulus(1, 0, 0, 0, 10'd0, 10'd0);
    $display("[TB] formation march from reset");
    repeat (80) applyStimulus(0, 0, 1, 0, 10'd0, 10'd0);
    aimLaser(lx, ly);
    applyStimulus(0, 0, 1, 1, 10'(mx + GAP * 2 + 5), 10'(my + 8));
    applyStimulus(0, 0, 1, 1, 10'(mx + GAP * 2 + 5), 10'(my + 8));

    $display("[TB] random laser traffic");
    for (int c = 0; c < 6000; c++) begin
      r  = ($urandom_range(0, 999) == 0);
      a  = ($urandom_range(0, 999) == 0);
      f  = ($urandom_range(0, 1) == 1);
      la = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) begin
        lx = 10'($urandom_range(0, 1023));
        ly = 10'($urandom_range(0, 511));
      end else begin
        aimLaser(lx, ly);
      end
      applyStimulus(r, a, f, la, lx, ly);
    end

    $display("[TB] descend to player row");
    applyStimulus(1, 0, 0, 0, 10'd0, 10'd0);
    b0 = breaches;
    n  = 0;
    while (breaches == b0 && n < 40000) begin
      applyStimulus(0, 0, ($urandom_range(0, 15) != 0), 0, 10'd0, 10'd0);
      n++;
    end
    if (breaches == b0) reportTimeout("breach_wait", 40000);
    repeat (200) applyStimulus(0, 0, 1, 0, 10'd0, 10'd0);

    $display("[TB] game reset during drop");
    n = 0;
    while (!pend_drop && n < 3000) begin
      applyStimulus(0, 0, 1, 0, 10'd0, 10'd0);
      n++;
    end
    if (!pend_drop) reportTimeout("drop_wait", 3000);
    applyStimulus(0, 1, 1, 1, 10'(mx + 4), 10'(my + 4));
    applyStimulus(0, 0, 1, 1, 10'(mx + 4), 10'(my + 4));
    repeat (50) applyStimulus(0, 0, 1, 0, 10'd0, 10'd0);

    applyStimulus(0, 0, 0, 0, 10'd0, 10'd0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
